// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StHold = 2'b10
  } state_e;

  // ALU operation codes, same encoding as the ALU controller output
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluXor = 4'b0011;
  localparam logic [3:0] AluSub = 4'b0100;
  localparam logic [3:0] AluBeq = 4'b1000;

  // Requester identifier: 0 = EX stage, 1 = auxiliary
  typedef logic req_id_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way grant decision. Build option: ALU_ARB_FIXED_PRIO_EN makes requester 0
// win every tie; otherwise the requester that did not win last time wins a tie.
module alu_arb_grant
  import alu_arbiter_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  req_id_t    ptr_i,
  output logic [1:0] grant_o
);

  // One-hot grant: bit 0 = requester 0, bit 1 = requester 1
  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_o = 2'b01;
`else
      grant_o = (ptr_i == 1'b1) ? 2'b01 : 2'b10;
`endif
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates a single shared ALU between the EX stage and an auxiliary requester.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              busy
);

  localparam int unsigned CntW = 2;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  req_id_t           last_q, last_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              resp_valid_q, resp_valid_d;
  req_id_t           resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_zero_q, resp_zero_d;

  logic       idle;
  logic [1:0] grant;

  assign idle = (state_q == StIdle);

  // Requests are only visible to the grant logic while idle
  alu_arb_grant u_grant (
    .valid0_i (req0_valid && idle),
    .valid1_i (req1_valid && idle),
    .ptr_i    (last_q),
    .grant_o  (grant)
  );

  // Next-state: launch on grant, count down the ALU latency, hold until taken
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          state_d   = StExec;
          cnt_d     = CntW'(ALU_LAT - 1);
          last_d    = grant[1];
          resp_id_d = grant[1];
          alu_op_d  = grant[1] ? req1_op : req0_op;
          alu_a_d   = grant[1] ? req1_a  : req0_a;
          alu_b_d   = grant[1] ? req1_b  : req0_b;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          resp_data_d  = alu_result;
          resp_zero_d  = alu_zero;
          resp_valid_d = 1'b1;
          state_d      = StHold;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StHold: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      alu_op_q     <= 4'b0000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW  = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_op = '0, req1_op = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_zero;
  logic          resp_valid, resp_ready = 1'b0, resp_id, resp_zero, busy;
  logic [DW-1:0] resp_data;

  // Second instance at ALU_LAT=4; shares ops/operands/resp_ready
  logic          v0_4 = 1'b0, v1_4 = 1'b0;
  logic          r0_4, r1_4;
  logic [3:0]    alu_op4;
  logic [DW-1:0] alu_a4, alu_b4, alu_result4, resp_data4;
  logic          alu_zero4, resp_valid4, resp_id4, resp_zero4, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      AluAdd:         return a + b;
      AluSub, AluBeq: return a - b;
      AluXor:         return a ^ b;
      AluOr:          return a | b;
      default:        return '0;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero    = (alu_result == '0);
  assign alu_result4 = alu_f(alu_op4, alu_a4, alu_b4);
  assign alu_zero4   = (alu_result4 == '0);

  alu_arbiter #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .busy(busy)
  );

  alu_arbiter #(.DATA_W(DW), .ALU_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(v0_4), .req0_ready(r0_4), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(v1_4), .req1_ready(r1_4), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_result(alu_result4), .alu_zero(alu_zero4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_id(resp_id4),
    .resp_data(resp_data4), .resp_zero(resp_zero4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " resp_valid"}, resp_valid, 0);
    chk({tag, " resp_id"},    resp_id, 0);
    chk({tag, " resp_data"},  resp_data, 0);
    chk({tag, " resp_zero"},  resp_zero, 0);
    chk({tag, " alu_op"},     alu_op, 0);
    chk({tag, " alu_a"},      alu_a, 0);
    chk({tag, " alu_b"},      alu_b, 0);
    chk({tag, " busy"},       busy, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    v0_4 = 1'b0; v1_4 = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v0;
    logic          v1;
    logic [3:0]    op0;
    logic [DW-1:0] a0;
    logic [DW-1:0] b0;
    logic [3:0]    op1;
    logic [DW-1:0] a1;
    logic [DW-1:0] b1;
    logic          exp_id;
    logic [DW-1:0] exp_data;
    logic          exp_zero;
  } vec_t;

  vec_t vecs[8];

  // One full transaction on the LAT=1 instance, then one idle cycle
  task automatic run_vec(input int idx);
    vec_t  v;
    string t;
    v = vecs[idx];
    t = $sformatf("vec%0d", idx);
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    @(negedge clk);
    chk({t, " ready0"}, req0_ready, v.exp_id == 1'b0);
    chk({t, " ready1"}, req1_ready, v.exp_id == 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk({t, " early resp_valid"}, resp_valid, 0);
      chk({t, " busy"}, busy, 1);
      chk({t, " alu_op"}, alu_op, v.exp_id ? v.op1 : v.op0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({t, " resp_valid"}, resp_valid, 1);
    chk({t, " resp_id"}, resp_id, v.exp_id);
    chk({t, " resp_data"}, resp_data, v.exp_data);
    chk({t, " resp_zero"}, resp_zero, v.exp_zero);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({t, " idle busy"}, busy, 0);
    chk({t, " idle resp_valid"}, resp_valid, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_busy;
  int            m_age;       // cycles since accept
  bit            m_last;
  logic [3:0]    m_op;
  logic [DW-1:0] m_a, m_b, m_res;
  bit            m_rid;
  logic [3:0]    ops[5];

  function automatic void m_init();
    m_busy = 0; m_age = 0; m_last = 1; m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_rid = 0;
  endfunction

  function automatic int m_winner(input bit v0, input bit v1);
    if (m_busy) return -1;
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return m_last ? 0 : 1;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic rand_cycle();
    int w;
    bit rv;
    req0_valid = ($urandom_range(0, 2) != 0);
    req1_valid = ($urandom_range(0, 2) != 0);
    req0_op = ops[$urandom_range(0, 4)];
    req1_op = ops[$urandom_range(0, 4)];
    req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
    req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
    resp_ready = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    w  = m_winner(req0_valid, req1_valid);
    rv = m_busy && (m_age >= LAT + 1);
    chk("rnd ready0", req0_ready, w == 0);
    chk("rnd ready1", req1_ready, w == 1);
    chk("rnd busy", busy, m_busy);
    chk("rnd resp_valid", resp_valid, rv);
    chk("rnd alu_op", alu_op, m_op);
    chk("rnd alu_a", alu_a, m_a);
    chk("rnd alu_b", alu_b, m_b);
    if (rv) begin
      chk("rnd resp_id", resp_id, m_rid);
      chk("rnd resp_data", resp_data, m_res);
      chk("rnd resp_zero", resp_zero, m_res == '0);
    end
    if (w >= 0) begin
      m_busy = 1; m_age = 1; m_last = (w == 1); m_rid = (w == 1);
      m_op  = (w == 1) ? req1_op : req0_op;
      m_a   = (w == 1) ? req1_a : req0_a;
      m_b   = (w == 1) ? req1_b : req0_b;
      m_res = alu_f(m_op, m_a, m_b);
    end else if (m_busy) begin
      if (rv && resp_ready) m_busy = 0;
      else m_age++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    ops = '{AluAdd, AluSub, AluXor, AluOr, AluBeq};
    vecs[0] = '{1'b1, 1'b1, AluAdd, 32'd1, 32'd2, AluSub, 32'd10, 32'd4, 1'b0, 32'd3, 1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
    vecs[1] = '{1'b1, 1'b1, AluAdd, 32'd3, 32'd4, AluSub, 32'd20, 32'd5, 1'b0, 32'd7, 1'b0};
    vecs[3] = '{1'b1, 1'b1, AluOr, 32'h3, 32'hC, AluAdd, 32'd100, 32'd1, 1'b0, 32'hF, 1'b0};
`else
    vecs[1] = '{1'b1, 1'b1, AluAdd, 32'd3, 32'd4, AluSub, 32'd20, 32'd5, 1'b1, 32'd15, 1'b0};
    vecs[3] = '{1'b1, 1'b1, AluOr, 32'h3, 32'hC, AluAdd, 32'd100, 32'd1, 1'b1, 32'd101, 1'b0};
`endif
    vecs[2] = '{1'b1, 1'b1, AluXor, 32'hF0, 32'h0F, AluOr, 32'h100, 32'h1, 1'b0, 32'hFF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, AluAdd, 32'd5, 32'd7, AluAdd, 32'd0, 32'd0, 1'b0, 32'd12, 1'b0};
    vecs[5] = '{1'b0, 1'b1, AluAdd, 32'd0, 32'd0, AluOr, 32'hA0, 32'h0B, 1'b1, 32'hAB, 1'b0};
    vecs[6] = '{1'b0, 1'b1, AluAdd, 32'd0, 32'd0, AluBeq, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, AluSub, 32'd7, 32'd8, AluAdd, 32'd2, 32'd2, 1'b0, 32'hFFFFFFFF, 1'b0};

    // Reset values while reset is held
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("por");
    apply_reset();

    // Back-to-back ties from reset: 0,1,0,1 (round-robin) or 0,0,0,0 (fixed)
    for (int i = 0; i < 4; i++) run_vec(i);
    // ADD 5+7 straight out of reset, then single requesters and a tie
    apply_reset();
    for (int i = 4; i < 8; i++) run_vec(i);

    // SUB 9-9 from requester 1 with the consumer stalling for 5 cycles
    apply_reset();
    req1_valid = 1'b1; req1_op = AluSub; req1_a = 32'd9; req1_b = 32'd9;
    req0_op = AluAdd; req0_a = 32'd1; req0_b = 32'd1;
    @(negedge clk);
    chk("stall accept ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("stall exec resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall resp_valid", resp_valid, 1);
      chk("stall resp_data", resp_data, 0);
      chk("stall resp_zero", resp_zero, 1);
      chk("stall resp_id", resp_id, 1);
      chk("stall busy", busy, 1);
      chk("stall ready0", req0_ready, 0);
      chk("stall ready1", req1_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("handshake ready0", req0_ready, 0);
    chk("handshake ready1", req1_ready, 0);
    chk("handshake resp_valid", resp_valid, 1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post handshake busy", busy, 0);
    chk("post handshake resp_valid", resp_valid, 0);
    chk("post handshake tie ready0", req0_ready, 1);
    chk("post handshake tie ready1", req1_ready, 0);
    @(posedge clk); #1;

    // ALU_LAT=4 instance: XOR 0xF0^0xFF, response exactly 5 cycles after accept
    apply_reset();
    v0_4 = 1'b1; req0_op = AluXor; req0_a = 32'hF0; req0_b = 32'hFF;
    @(negedge clk);
    chk("lat4 ready0", r0_4, 1);
    @(posedge clk); #1;
    v0_4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat4 cycle%0d resp_valid", c), resp_valid4, 0);
      chk($sformatf("lat4 cycle%0d busy", c), busy4, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lat4 resp_valid", resp_valid4, 1);
    chk("lat4 resp_data", resp_data4, 32'h0F);
    chk("lat4 resp_id", resp_id4, 0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("lat4 idle busy", busy4, 0);
    @(posedge clk); #1;

    // Randomized run against the model
    apply_reset();
    m_init();
    for (int n = 0; n < 1500; n++) rand_cycle();

    // Reset from whatever state the random run left
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid-run reset");
    reset = 1'b1;

    // Reset during EXEC discards the operation
    req0_valid = 1'b1; req0_op = AluAdd; req0_a = 32'd5; req0_b = 32'd6;
    @(negedge clk);
    chk("exec-reset accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("exec-reset busy before", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("exec-reset");
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("exec-reset no resp", resp_valid, 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("exec-reset tie ready0", req0_ready, 1);
    chk("exec-reset tie ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width.
REQ-002 Parameter ALU_LAT, default 1, legal 1..4: cycles from operand launch to valid alu_result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req0_valid, req1_valid  input  1  requester n (0 = EX stage, 1 = auxiliary) presents an operation.
REQ-006 req0_ready, req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-007 req0_op, req1_op  input  4  ALU operation code, same encoding as the ALU controller output.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-009 alu_op  output  4  registered operation driven to the shared ALU.
REQ-010 alu_a, alu_b  output  DATA_W  registered operands driven to the shared ALU.
REQ-011 alu_result  input  DATA_W  shared ALU result.
REQ-012 alu_zero  input  1  shared ALU zero/branch flag.
REQ-013 resp_valid  output  1  response holds a result.
REQ-014 resp_ready  input  1  consumer takes the response.
REQ-015 resp_id  output  1  requester that owns the response.
REQ-016 resp_data  output  DATA_W  captured alu_result.
REQ-017 resp_zero  output  1  captured alu_zero.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, EXEC, HOLD.
REQ-020 IDLE: at most one reqN_ready high, only when reqN_valid is high; an accepted op and operands load into alu_op/alu_a/alu_b; the latency counter loads ALU_LAT-1; the next state is EXEC.
REQ-021 In EXEC and HOLD, req0_ready and req1_ready are 0.
REQ-022 EXEC: the counter decrements each cycle; at count 0, alu_result/alu_zero are captured into resp_data/resp_zero, resp_valid is set, and the next state is HOLD.
REQ-023 Accept-to-resp_valid latency is exactly ALU_LAT+1 cycles.
REQ-024 HOLD: the response is held stable until resp_valid && resp_ready; on that cycle resp_valid clears and the next state is IDLE.
REQ-025 No new grant occurs in the handshake cycle; minimum issue interval is ALU_LAT+2 cycles.
REQ-026 Only one request valid: that requester is granted.
REQ-027 Both valid (round-robin): the requester not granted last time wins; the last-grant pointer updates on every grant.
REQ-028 alu_op/alu_a/alu_b hold their values outside grant cycles.
REQ-029 A requester dropping valid without ready causes no state change; no request is queued.

Reset
REQ-030 While reset=0 at a clock edge: state IDLE, resp_valid 0, resp_id 0, resp_data 0, resp_zero 0, alu_op 4'b0000, alu_a 0, alu_b 0, counter 0, last-grant pointer 1, busy 0.
REQ-031 Reset in EXEC or HOLD discards the operation without emitting a response.
REQ-032 The first tie after reset grants requester 0.

Configuration
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and the last-grant pointer is unused.
REQ-034 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-027.

Structure
REQ-035 A shared package holds: the state enum, the 4-bit ALU operation constants (ADD 0010, SUB 0100, XOR 0011, OR 0001, BEQ 1000), and the requester-id typedef.
REQ-036 The grant decision is a sub-module alu_arb_grant (inputs: two valids, pointer; output: one-hot grant).

Verification
REQ-037 Reset release, req0 ADD a=5 b=7, ALU_LAT=1 -> req0_ready in cycle 0; resp_valid in cycle 2 with resp_data=12, resp_id=0.
REQ-038 Both valid in consecutive IDLE windows, round-robin build -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-039 req1 SUB a=9 b=9, resp_ready held low 5 cycles -> resp_data=0, resp_zero=1 held stable, busy=1, no grant until the handshake; IDLE on the following cycle.
REQ-040 ALU_LAT=4, req0 XOR a=0xF0 b=0xFF -> resp_valid exactly 5 cycles after accept, resp_data=0x0F.
REQ-041 Reset asserted during EXEC -> resp_valid never rises; all outputs at REQ-030 values; the next tie grants requester 0.
